mt_state_recover: RTL
=====================

Name: mt_state_recover

Overview:
- Consumer-side companion to the Mersenne Twister generator: drives the generator's trig/ready extraction handshake and captures N consecutive tempered outputs.
- Applies inverse tempering (untempering) to each captured output, which recovers the generator's internal state words in order.
- Streams the recovered words out with their index, for state cloning, prediction checks and self-test.
- Sits beside the generator in the RNG test/verification subsystem.

Parameters:
N, 624, number of state words to recover (degree of recurrence)
U, 11, tempering shift 1 (right)
D, 32'hFFFFFFFF, tempering mask 1
S, 7, tempering shift 2 (left)
B, 32'h9D2C5680, tempering mask 2
T, 15, tempering shift 3 (left)
C, 32'hEFC60000, tempering mask 3
L, 18, tempering shift 4 (right)
SETTLE, 2, cycles after a trig pulse before mt_r_num is sampled again (covers generator index update plus SRAM read)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins a recovery run (ignored unless IDLE or DONE)
mt_ready  in  1  generator extraction-ready level
mt_r_num  in  32  generator tempered output
mt_trig  out  1  one-cycle pulse; acknowledges/advances generator output
st_word  out  32  recovered (untempered) state word
st_idx  out  $clog2(N)  index of st_word, 0..N-1
st_valid  out  1  one-cycle pulse; st_word/st_idx valid
busy  out  1  high from accepted start until DONE
done  out  1  high in DONE until next accepted start or rst

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset: state IDLE; mt_trig=0, st_valid=0, busy=0, done=0, st_word=0, st_idx=0, settle counter=0.
- FSM states: IDLE, WAIT, INV_L, INV_T, INV_S, INV_U, EMIT, DONE.
- IDLE/DONE + start: idx<=0, settle<=0, busy<=1, done<=0, go to WAIT.
- WAIT: if mt_ready && settle==0, then:
  - y<=mt_r_num, x<=mt_r_num, mt_trig=1 in that same cycle.
  - settle<=SETTLE, go to INV_L.
  - Otherwise stay. While nonzero, settle decrements every cycle in all states.
- Inverse stages: each runs k=ceil(32/shift) cycles with an iteration counter. Each cycle:
  - Right-shift stages: x <= y ^ ((x >> shift) & mask).
  - Left-shift stages: x <= y ^ ((x << shift) & mask).
  - On stage exit, y<=x for the next stage.
- Stage order and shift/mask pairs:
  - INV_L: shift L, mask all-ones.
  - INV_T: shift T, mask C.
  - INV_S: shift S, mask B.
  - INV_U: shift U, mask D.
- With the default parameters, k = 2, 3, 5, 3, giving 13 inversion cycles. k is computed from parameters at elaboration time.
- EMIT: st_word<=x, st_idx<=idx, st_valid=1 for one cycle.
  - If idx==N-1, go to DONE (busy=0, done=1).
  - Otherwise idx++ and go to WAIT.
- Latency: sample cycle to st_valid is 1+13+1 = 15 cycles with defaults. Throughput is one word per 15 cycles minimum.
- mt_trig is never asserted while mt_ready=0. It is never asserted twice within SETTLE+1 cycles.
- mt_ready dropping during inversion: no effect. WAIT simply stalls until it returns.
- start while busy: ignored.
- rst mid-run: immediate return to reset values. Partial results are discarded and no further mt_trig is issued.
- All arithmetic is 32-bit. Shifts are logical and zero-fill. st_idx wraps never, because the run ends at N-1.

Decomposition:
- Shared package mt_pkg holds the MT19937 constants (N, M, R, A, U, D, S, B, T, C, L, F) and the FSM state typedef. The generator and this block both use it.
- One sub-module, mt_inv_shift, is natural: a parameterised single inverse stage (shift, direction, mask, iteration count) with start/done. It is instantiated four times, or time-shared through a single instance with muxed parameters.

Test Plan:
- Stub generator holds mt_r_num=32'h00400091 with mt_ready=1, N=1 -> st_word=32'h00000001, st_idx=0, st_valid 15 cycles after the mt_trig pulse, done=1.
- mt_r_num=32'h00000000 -> st_word=32'h00000000. Separately, a round-trip with 1000 random words tempered by the bench model -> each recovered word equals the original.
- Stub mt_ready toggling 0/1 every 7 cycles -> mt_trig occurs only when mt_ready=1, spacing is at least SETTLE+1, and no word is skipped or duplicated.
- Full system with the real generator, seed 5489, N=624 -> first capture equals 32'hD091BB5C; a golden model loaded with the 624 recovered words predicts the generator's 625th output exactly.
- rst asserted at word 100 -> all outputs return to 0 next cycle and no mt_trig follows. A subsequent start restarts from st_idx=0.
- start pulsed during a run -> ignored: busy stays 1 and the st_idx sequence is unbroken.

Source files
------------

// File: rtl/mt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mt_pkg
//  Purpose  : MT19937 constants shared by the generator and the state
//             recovery block, plus the recovery FSM state type.
//  Revision : 1.0 - initial release
// ============================================================================
package mt_pkg;

  // MT19937 recurrence and tempering constants
  localparam int          MT_W      = 32;
  localparam int          MT_N      = 624;
  localparam int          MT_M      = 397;
  localparam int          MT_R      = 31;
  localparam logic [31:0] MT_A      = 32'h9908B0DF;
  localparam int          MT_U      = 11;
  localparam logic [31:0] MT_D      = 32'hFFFFFFFF;
  localparam int          MT_S      = 7;
  localparam logic [31:0] MT_B      = 32'h9D2C5680;
  localparam int          MT_T      = 15;
  localparam logic [31:0] MT_C      = 32'hEFC60000;
  localparam int          MT_L      = 18;
  localparam logic [31:0] MT_F      = 32'd1812433253;

  // Cycles between an extraction pulse and the next valid sample of the
  // generator output (index update plus SRAM read).
  localparam int          MT_SETTLE = 2;

  // Recovery FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_INV_L = 3'd2,
    ST_INV_T = 3'd3,
    ST_INV_S = 3'd4,
    ST_INV_U = 3'd5,
    ST_EMIT  = 3'd6,
    ST_DONE  = 3'd7
  } rec_state_t;

  // Number of fixed-point iterations an inverse xorshift stage needs.
  function automatic int inv_iters(input int shift);
    return (MT_W + shift - 1) / shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mt_inv_shift.sv
`default_nettype none
// ============================================================================
//  Module   : mt_inv_shift
//  Purpose  : One inverse-tempering stage, time-shared across the four
//             stages. Computes x' = y ^ ((x <shift> s) & mask) and counts
//             iterations while i_run is high; o_done flags the final one.
//  Revision : 1.0 - initial release
// ============================================================================
module mt_inv_shift #(
  parameter int KW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_run,
  input  logic          i_left,
  input  logic [4:0]    i_shift,
  input  logic [31:0]   i_mask,
  input  logic [KW-1:0] i_k,
  input  logic [31:0]   i_x,
  input  logic [31:0]   i_y,
  output logic [31:0]   o_x_next,
  output logic          o_done
);

  logic [KW-1:0] r_iter;
  logic [31:0]   w_shifted;

  // One fixed-point step of the inverse xorshift (logical, zero-fill shifts)
  always_comb begin
    w_shifted = i_left ? (i_x << i_shift) : (i_x >> i_shift);
    o_x_next  = i_y ^ (w_shifted & i_mask);
  end

  assign o_done = i_run && (r_iter == (i_k - KW'(1)));

  // Iteration counter; restarts at zero for each new stage
  always_ff @(posedge clk) begin
    if (rst || !i_run || o_done) begin
      r_iter <= '0;
    end else begin
      r_iter <= r_iter + KW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mt_state_recover.sv
`default_nettype none
// ============================================================================
//  Module   : mt_state_recover
//  Purpose  : Drives the generator extraction handshake, captures N tempered
//             outputs, untempers each one and streams the recovered state
//             words out with their index.
//  Revision : 1.0 - initial release
// ============================================================================
module mt_state_recover
  import mt_pkg::*;
#(
  parameter int          N      = MT_N,
  parameter int          U      = MT_U,
  parameter logic [31:0] D      = MT_D,
  parameter int          S      = MT_S,
  parameter logic [31:0] B      = MT_B,
  parameter int          T      = MT_T,
  parameter logic [31:0] C      = MT_C,
  parameter int          L      = MT_L,
  parameter int          SETTLE = MT_SETTLE
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                mt_ready,
  input  logic [31:0]                         mt_r_num,
  output logic                                mt_trig,
  output logic [31:0]                         st_word,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] st_idx,
  output logic                                st_valid,
  output logic                                busy,
  output logic                                done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int KW = 6;

  localparam logic [KW-1:0] c_k_l = KW'(inv_iters(L));
  localparam logic [KW-1:0] c_k_t = KW'(inv_iters(T));
  localparam logic [KW-1:0] c_k_s = KW'(inv_iters(S));
  localparam logic [KW-1:0] c_k_u = KW'(inv_iters(U));

  rec_state_t     r_state;
  logic [IW-1:0]  r_idx;
  logic [SW-1:0]  r_settle;
  logic [31:0]    r_x;
  logic [31:0]    r_y;

  logic           w_capture;
  logic           w_run;
  logic           w_left;
  logic [4:0]     w_shift;
  logic [31:0]    w_mask;
  logic [KW-1:0]  w_k;
  rec_state_t     w_stage_next;
  logic [31:0]    w_x_next;
  logic           w_stage_done;

  // The acknowledge must coincide with the sample, so it is decoded from the
  // current state rather than registered; rst suppresses it immediately.
  assign w_capture = !rst && (r_state == ST_WAIT) && mt_ready && (r_settle == '0);
  assign mt_trig   = w_capture;

  // Select the shift/mask/iteration set of the active inverse stage
  always_comb begin
    w_run        = 1'b1;
    w_left       = 1'b0;
    w_shift      = 5'd0;
    w_mask       = 32'h0;
    w_k          = KW'(1);
    w_stage_next = ST_IDLE;
    case (r_state)
      ST_INV_L: begin
        w_shift = 5'(L); w_mask = 32'hFFFFFFFF; w_k = c_k_l; w_stage_next = ST_INV_T;
      end
      ST_INV_T: begin
        w_left = 1'b1; w_shift = 5'(T); w_mask = C; w_k = c_k_t; w_stage_next = ST_INV_S;
      end
      ST_INV_S: begin
        w_left = 1'b1; w_shift = 5'(S); w_mask = B; w_k = c_k_s; w_stage_next = ST_INV_U;
      end
      ST_INV_U: begin
        w_shift = 5'(U); w_mask = D; w_k = c_k_u; w_stage_next = ST_EMIT;
      end
      default: begin
        w_run = 1'b0;
      end
    endcase
  end

  mt_inv_shift #(
    .KW (KW)
  ) u_inv (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .i_left   (w_left),
    .i_shift  (w_shift),
    .i_mask   (w_mask),
    .i_k      (w_k),
    .i_x      (r_x),
    .i_y      (r_y),
    .o_x_next (w_x_next),
    .o_done   (w_stage_done)
  );

  // Recovery sequencer: capture, four inverse stages, emit, repeat N times
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_settle <= '0;
      r_x      <= '0;
      r_y      <= '0;
      st_word  <= '0;
      st_idx   <= '0;
      st_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      st_valid <= 1'b0;
      if (r_settle != '0) begin
        r_settle <= r_settle - SW'(1);
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_idx    <= '0;
            r_settle <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_capture) begin
            r_y      <= mt_r_num;
            r_x      <= mt_r_num;
            r_settle <= SW'(SETTLE);
            r_state  <= ST_INV_L;
          end
        end
        ST_INV_L, ST_INV_T, ST_INV_S, ST_INV_U: begin
          r_x <= w_x_next;
          if (w_stage_done) begin
            r_y     <= w_x_next;
            r_state <= w_stage_next;
          end
        end
        ST_EMIT: begin
          st_word  <= r_x;
          st_idx   <= r_idx;
          st_valid <= 1'b1;
          if (r_idx == IW'(N - 1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_state <= ST_WAIT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
